// File: rtl/spi_slave_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spi_slave_responder                                              |
// | Brief   : Mode-0 SPI target, oversampled on sys_clk, byte handshakes.      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module spi_slave_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic r_sck_d, r_cs_d;
  logic w_sck_s, w_cs_s, w_mosi_s;

  // cs_n chain resets high so reset release never looks like a select
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sck_d     <= w_sck_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_cs_fall  = ~w_cs_s & r_cs_d;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_next = ACTIVE;
      ACTIVE:  if (w_cs_rise) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_sr, r_tx_sr, r_tx_buf;
  logic       r_tx_full, r_reload_pend;
  logic       r_miso, r_rx_valid, r_rx_overrun, r_tx_underrun;
  logic [7:0] r_rx_data;

  logic       w_enter, w_leave, w_rise_act, w_fall_act;
  logic       w_rx_done, w_reload_fall, w_consume, w_tx_accept;
  logic [7:0] w_load_byte, w_rx_next, w_tx_shift;

  // cs_n deassertion outranks a coincident sck edge
  assign w_enter       = (r_state == IDLE) && w_cs_fall;
  assign w_leave       = (r_state == ACTIVE) && w_cs_rise;
  assign w_rise_act    = (r_state == ACTIVE) && !w_cs_rise && w_sck_rise;
  assign w_fall_act    = (r_state == ACTIVE) && !w_cs_rise && w_sck_fall;
  assign w_rx_done     = w_rise_act && (r_bit_cnt == 3'd7);
  assign w_reload_fall = w_fall_act && r_reload_pend;
  assign w_consume     = w_enter || w_reload_fall;
  assign w_load_byte   = r_tx_full ? r_tx_buf : IDLE_BYTE;
  assign w_tx_accept   = tx_load && (!r_tx_full || w_consume);
  assign w_rx_next     = {r_rx_sr[6:0], w_mosi_s};
  assign w_tx_shift    = {r_tx_sr[6:0], 1'b0};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bit_cnt     <= 3'd0;
      r_rx_sr       <= 8'd0;
      r_tx_sr       <= 8'd0;
      r_reload_pend <= 1'b0;
      r_miso        <= 1'b0;
    end else if (w_enter) begin
      r_bit_cnt     <= 3'd0;
      r_rx_sr       <= 8'd0;
      r_tx_sr       <= w_load_byte;
      r_miso        <= w_load_byte[7];
      r_reload_pend <= 1'b0;
    end else if (w_leave) begin
      r_bit_cnt     <= 3'd0;
      r_rx_sr       <= 8'd0;
      r_reload_pend <= 1'b0;
    end else if (w_rise_act) begin
      r_rx_sr   <= w_rx_next;
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_rx_done) r_reload_pend <= 1'b1;
    end else if (w_fall_act) begin
      if (r_reload_pend) begin
        r_tx_sr       <= w_load_byte;
        r_miso        <= w_load_byte[7];
        r_reload_pend <= 1'b0;
      end else begin
        r_tx_sr <= w_tx_shift;
        r_miso  <= w_tx_shift[7];
      end
    end
  end

  // A completion coinciding with rx_ack keeps the new byte valid
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rx_data    <= 8'd0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_rx_done) begin
        r_rx_data  <= w_rx_next;
        r_rx_valid <= 1'b1;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
      if (rx_ack)                       r_rx_overrun <= 1'b0;
      else if (w_rx_done && r_rx_valid) r_rx_overrun <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tx_buf      <= 8'd0;
      r_tx_full     <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      if (w_tx_accept) begin
        r_tx_buf  <= tx_data;
        r_tx_full <= 1'b1;
      end else if (w_consume) begin
        r_tx_full <= 1'b0;
      end
      if (w_consume && !r_tx_full) r_tx_underrun <= 1'b1;
      else if (tx_load)            r_tx_underrun <= 1'b0;
    end
  end

  assign miso        = r_miso;
  assign miso_oe     = ~w_cs_s;
  assign busy        = ~w_cs_s;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_rx_overrun;
  assign tx_ready    = ~r_tx_full;
  assign tx_underrun = r_tx_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_spi_slave_responder                                           |
// | Brief   : Directed vector bench for spi_slave_responder, sck = sys_clk/8.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_spi_slave_responder;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       sck, cs_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ack, rx_overrun;
  logic [7:0] tx_data;
  logic       tx_load, tx_ready, tx_underrun, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  spi_slave_responder #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sck        (sck),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .busy       (busy)
  );

  typedef struct {
    logic       first;
    logic       last;
    logic       load;
    logic [7:0] tx;
    logic [7:0] mosi_b;
    logic [7:0] exp_miso;
    logic       ack;
    logic       exp_ovr;
    logic       exp_unr;
  } vec_t;

  vec_t vecs[9];

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] d);
    tx_data = d; tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  task automatic start_txn();
    cs_n = 1'b0;
    tick(6);
  endtask

  // leaves sck high after the last bit; the trailing fall comes from end_txn
  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      sck = 1'b0; mosi = mo[7-i];
      tick(4);
      mi[7-i] = miso;
      sck = 1'b1;
      tick(4);
    end
  endtask

  task automatic end_txn();
    sck = 1'b0;
    tick(4);
    cs_n = 1'b1;
    tick(6);
  endtask

  initial begin
    logic [7:0] mi;

    //            first last load tx     mosi   miso   ack  ovr  unr
    vecs[0] = '{1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 8'h11, 8'hC1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h22, 8'hC2, 8'h22, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h33, 8'hC3, 8'h33, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h96, 8'hFF, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 8'h4D, 8'hB2, 8'h4D, 1'b1, 1'b0, 1'b0};

    sys_rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    rx_ack = 1'b0; tx_data = 8'h00; tx_load = 1'b0;
    tick(3);
    check("rst_miso",     miso,        8'h0);
    check("rst_miso_oe",  miso_oe,     8'h0);
    check("rst_rx_data",  rx_data,     8'h00);
    check("rst_rx_valid", rx_valid,    8'h0);
    check("rst_overrun",  rx_overrun,  8'h0);
    check("rst_tx_ready", tx_ready,    8'h1);
    check("rst_underrun", tx_underrun, 8'h0);
    check("rst_busy",     busy,        8'h0);
    sys_rst_n = 1'b1;
    tick(2);

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].load) do_load(vecs[v].tx);
      if (vecs[v].first) begin
        start_txn();
        check($sformatf("v%0d_busy", v), busy, 8'h1);
      end
      spi_bits(vecs[v].mosi_b, 8, mi);
      check($sformatf("v%0d_miso", v),     mi,          vecs[v].exp_miso);
      check($sformatf("v%0d_rx_data", v),  rx_data,     vecs[v].mosi_b);
      check($sformatf("v%0d_rx_valid", v), rx_valid,    8'h1);
      check($sformatf("v%0d_overrun", v),  rx_overrun,  {7'd0, vecs[v].exp_ovr});
      check($sformatf("v%0d_underrun", v), tx_underrun, {7'd0, vecs[v].exp_unr});
      check($sformatf("v%0d_tx_ready", v), tx_ready,    8'h1);
      if (vecs[v].ack) begin
        do_ack();
        check($sformatf("v%0d_ack_valid", v), rx_valid,   8'h0);
        check($sformatf("v%0d_ack_ovr", v),   rx_overrun, 8'h0);
      end
      if (vecs[v].last) begin
        end_txn();
        check($sformatf("v%0d_oe_off", v), miso_oe, 8'h0);
      end
      // last vector of the overrun pair: acknowledge clears both flags
      if (v == 7) begin
        do_ack();
        check("ovr_ack_valid", rx_valid,   8'h0);
        check("ovr_ack_ovr",   rx_overrun, 8'h0);
        // underrun set by the trailing fall here; a load clears it
        do_load(8'h4D);
        check("unr_cleared", tx_underrun, 8'h0);
        check("ready_low",   tx_ready,    8'h0);
      end
      if (v == 7) begin
        do_load(8'h88);
        check("ignored_ready", tx_ready, 8'h0);
      end
    end

    // rx_ack coinciding with a completion: new byte stays valid
    do_load(8'h55);
    start_txn();
    spi_bits(8'h12, 8, mi);
    spi_bits(8'h34, 7, mi);
    sck = 1'b0; mosi = 1'b1; tick(4);
    sck = 1'b1; tick(2);
    rx_ack = 1'b1; tick(1); rx_ack = 1'b0;
    tick(2);
    check("sim_rx_data",  rx_data,    8'h35);
    check("sim_rx_valid", rx_valid,   8'h1);
    check("sim_overrun",  rx_overrun, 8'h0);
    end_txn();
    do_ack();

    // cs_n raised after five bits
    do_load(8'h77);
    start_txn();
    spi_bits(8'hA8, 5, mi);
    check("part_miso", mi, 8'h70);
    check("part_oe",   miso_oe, 8'h1);
    end_txn();
    check("part_valid", rx_valid, 8'h0);
    check("part_busy",  busy,     8'h0);
    start_txn();
    spi_bits(8'hE7, 8, mi);
    check("after_part_rx",    rx_data,  8'hE7);
    check("after_part_valid", rx_valid, 8'h1);
    check("after_part_miso",  mi,       8'hFF);
    end_txn();
    do_ack();

    // asynchronous reset mid-byte
    do_load(8'hC3);
    start_txn();
    spi_bits(8'hF0, 4, mi);
    check("pre_rst_miso", mi, 8'hC0);
    sys_rst_n = 1'b0;
    #1;
    check("arst_miso",     miso,        8'h0);
    check("arst_oe",       miso_oe,     8'h0);
    check("arst_rx_data",  rx_data,     8'h00);
    check("arst_tx_ready", tx_ready,    8'h1);
    check("arst_underrun", tx_underrun, 8'h0);
    check("arst_busy",     busy,        8'h0);
    tick(2);
    sck = 1'b0; cs_n = 1'b1;
    tick(4);
    sys_rst_n = 1'b1;
    tick(2);
    start_txn();
    spi_bits(8'h69, 8, mi);
    check("post_rst_rx",    rx_data,  8'h69);
    check("post_rst_valid", rx_valid, 8'h1);
    check("post_rst_miso",  mi,       8'hFF);
    end_txn();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
